// File: rtl/modinv_invert_loop_ctrl_pkg.sv
// Shared definitions for the modular-inversion main-loop controller.
// Holds the 3-bit state encoding and small state-classification helpers.
package modinv_invert_loop_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PREP_GO   = 3'd1;
  localparam state_t ST_PREP_WAIT = 3'd2;
  localparam state_t ST_CHECK     = 3'd3;
  localparam state_t ST_UPD_GO    = 3'd4;
  localparam state_t ST_UPD_WAIT  = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  function automatic logic is_go_state(input state_t s);
    return (s == ST_PREP_GO) || (s == ST_UPD_GO);
  endfunction

  function automatic logic is_wait_state(input state_t s);
    return (s == ST_PREP_WAIT) || (s == ST_UPD_WAIT);
  endfunction

endpackage

// File: rtl/modinv_invert_loop_ctrl_if.sv
// Handshake bundle between the modinv top FSM / helpers and the loop controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface modinv_invert_loop_ctrl_if #(
  parameter int ITER_CNT_BITS = 10
);

  logic                     ena;
  logic                     rdy;
  logic                     prep_ena;
  logic                     prep_rdy;
  logic                     upd_ena;
  logic                     upd_rdy;
  logic                     v_eq_1;
  logic [ITER_CNT_BITS-1:0] k;
  logic                     done_ok;
  logic                     err_overflow;

  modport slave (
    input  ena,
    input  prep_rdy,
    input  upd_rdy,
    input  v_eq_1,
    output rdy,
    output prep_ena,
    output upd_ena,
    output k,
    output done_ok,
    output err_overflow
  );

  modport master (
    output ena,
    output prep_rdy,
    output upd_rdy,
    output v_eq_1,
    input  rdy,
    input  prep_ena,
    input  upd_ena,
    input  k,
    input  done_ok,
    input  err_overflow
  );

endinterface

// File: rtl/modinv_invert_loop_ctrl.sv
// Main-loop sequencer of the binary modular inversion: precompute, test v==1,
// update, and count iterations k for the later correction phase.
module modinv_invert_loop_ctrl
  import modinv_invert_loop_ctrl_pkg::*;
#(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int MAX_ITER         = 512,
  parameter int ITER_CNT_BITS    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  modinv_invert_loop_ctrl_if.slave bus
);

  localparam logic [ITER_CNT_BITS-1:0] K_LIMIT = ITER_CNT_BITS'(MAX_ITER);
  localparam bit PARAMS_OK = (BUFFER_NUM_WORDS > 0) && ((2 ** ITER_CNT_BITS) > MAX_ITER);

  state_t                   state;
  state_t                   state_nx;
  logic                     guard;
  logic                     rdy_q;
  logic                     prep_ena_q;
  logic                     upd_ena_q;
  logic [ITER_CNT_BITS-1:0] k_q;
  logic                     done_ok_q;
  logic                     err_overflow_q;
  logic                     start;
  logic                     upd_exit;

  assign start    = (state == ST_IDLE) && bus.ena;
  assign upd_exit = (state == ST_UPD_WAIT) && !guard && bus.upd_rdy;

  // The helpers drop rdy only one cycle after their start pulse, so the first
  // wait cycle (guard=1) must not trust the still-high rdy from the idle helper.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (bus.ena) state_nx = ST_PREP_GO;
      ST_PREP_GO:   state_nx = ST_PREP_WAIT;
      ST_PREP_WAIT: if (!guard && bus.prep_rdy) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (bus.v_eq_1 || (k_q == K_LIMIT)) state_nx = ST_DONE;
        else                                state_nx = ST_UPD_GO;
      end
      ST_UPD_GO:    state_nx = ST_UPD_WAIT;
      ST_UPD_WAIT:  if (upd_exit) state_nx = ST_PREP_GO;
      ST_DONE:      state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // Strobes and rdy are decoded from the next state so they are registered yet
  // line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      guard      <= 1'b0;
      rdy_q      <= 1'b1;
      prep_ena_q <= 1'b0;
      upd_ena_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      guard      <= is_go_state(state);
      rdy_q      <= (state_nx == ST_IDLE);
      prep_ena_q <= (state_nx == ST_PREP_GO);
      upd_ena_q  <= (state_nx == ST_UPD_GO);
    end
  end

  // Result flags survive the return to IDLE and are only cleared by a new run;
  // v_eq_1 wins over the iteration limit when both hold in CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q            <= '0;
      done_ok_q      <= 1'b0;
      err_overflow_q <= 1'b0;
    end else if (start) begin
      k_q            <= '0;
      done_ok_q      <= 1'b0;
      err_overflow_q <= 1'b0;
    end else if (state == ST_CHECK) begin
      if (bus.v_eq_1)          done_ok_q      <= 1'b1;
      else if (k_q == K_LIMIT) err_overflow_q <= 1'b1;
    end else if (upd_exit) begin
      k_q <= k_q + 1'b1;
    end
  end

  assign bus.rdy          = rdy_q;
  assign bus.prep_ena     = prep_ena_q;
  assign bus.upd_ena      = upd_ena_q;
  assign bus.k            = k_q;
  assign bus.done_ok      = done_ok_q;
  assign bus.err_overflow = err_overflow_q;

  a_params_ok: assert property (@(posedge clk) PARAMS_OK);

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(prep_ena_q && upd_ena_q));

  a_rdy_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    rdy_q == (state == ST_IDLE));

  a_guard_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    guard |-> is_wait_state(state));

  a_results_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(done_ok_q && err_overflow_q));

endmodule

// File: tb/tb_modinv_invert_loop_ctrl.sv
// Directed bench for the inversion loop controller with stub precompute/update
// helpers (rdy low 5 cycles after each start) and a scripted v_eq_1.
module tb_modinv_invert_loop_ctrl;

  localparam int ITER_BITS = 10;
  localparam int BUDGET    = 400;

  typedef struct {
    int v_target;
    int exp_prep;
    int exp_upd;
    int exp_k;
    int exp_done;
    int exp_err;
  } vec_t;

  logic clk;
  logic rst_n;
  logic cnt_clr;
  int   v_target;
  int   prep_busy;
  int   upd_busy;
  int   prep_pulses;
  int   upd_pulses;
  int   last_pulse;
  logic seq_err;
  int   errors;
  int   checks;
  vec_t vecs[5];

  modinv_invert_loop_ctrl_if #(.ITER_CNT_BITS(ITER_BITS)) bus ();

  modinv_invert_loop_ctrl #(
    .BUFFER_NUM_WORDS (9),
    .MAX_ITER         (4),
    .ITER_CNT_BITS    (ITER_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.prep_rdy = (prep_busy == 0);
  assign bus.upd_rdy  = (upd_busy == 0);
  assign bus.v_eq_1   = (v_target != 0) && (prep_pulses >= v_target);

  // Stub helpers share rst_n with the controller.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prep_busy <= 0;
      upd_busy  <= 0;
    end else begin
      if (bus.prep_ena)    prep_busy <= 5;
      else if (prep_busy > 0) prep_busy <= prep_busy - 1;
      if (bus.upd_ena)     upd_busy <= 5;
      else if (upd_busy > 0)  upd_busy <= upd_busy - 1;
    end
  end

  // Pulse counting plus prep/upd alternation tracking (last_pulse: 1=prep, 2=upd).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || cnt_clr) begin
      prep_pulses <= 0;
      upd_pulses  <= 0;
      last_pulse  <= 0;
      seq_err     <= 1'b0;
    end else begin
      if (bus.prep_ena && bus.upd_ena) seq_err <= 1'b1;
      if (bus.prep_ena) begin
        if (last_pulse == 1) seq_err <= 1'b1;
        last_pulse  <= 1;
        prep_pulses <= prep_pulses + 1;
      end
      if (bus.upd_ena) begin
        if (last_pulse != 1) seq_err <= 1'b1;
        last_pulse <= 2;
        upd_pulses <= upd_pulses + 1;
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.rdy !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_finished"}, int'(bus.rdy), 1);
  endtask

  // Starts one loop run; with hold_ena the start request stays high for the
  // whole run to show that a busy controller ignores it.
  task automatic apply_stimulus(input int target, input bit hold_ena);
    v_target = target;
    cnt_clr  = 1'b1;
    @(negedge clk);
    cnt_clr  = 1'b0;
    bus.ena  = 1'b1;
    @(negedge clk);
    if (!hold_ena) bus.ena = 1'b0;
    check_output("busy_after_ena", int'(bus.rdy), 0);
    wait_idle("run");
    bus.ena = 1'b0;
  endtask

  task automatic run_and_check(input vec_t v, input bit hold_ena);
    apply_stimulus(v.v_target, hold_ena);
    check_output("prep_pulses",  prep_pulses,           v.exp_prep);
    check_output("upd_pulses",   upd_pulses,            v.exp_upd);
    check_output("k",            int'(bus.k),           v.exp_k);
    check_output("done_ok",      int'(bus.done_ok),     v.exp_done);
    check_output("err_overflow", int'(bus.err_overflow), v.exp_err);
    check_output("alternation",  int'(seq_err),         0);
  endtask

  initial begin
    int  seen;
    int  n;
    int  stray;

    errors   = 0;
    checks   = 0;
    v_target = 0;
    cnt_clr  = 1'b0;
    bus.ena  = 1'b0;
    rst_n    = 1'b0;

    vecs[0] = '{v_target: 1, exp_prep: 1, exp_upd: 0, exp_k: 0, exp_done: 1, exp_err: 0};
    vecs[1] = '{v_target: 4, exp_prep: 4, exp_upd: 3, exp_k: 3, exp_done: 1, exp_err: 0};
    vecs[2] = '{v_target: 0, exp_prep: 5, exp_upd: 4, exp_k: 4, exp_done: 0, exp_err: 1};
    vecs[3] = '{v_target: 2, exp_prep: 2, exp_upd: 1, exp_k: 1, exp_done: 1, exp_err: 0};
    vecs[4] = '{v_target: 3, exp_prep: 3, exp_upd: 2, exp_k: 2, exp_done: 1, exp_err: 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("reset_rdy",      int'(bus.rdy),          1);
    check_output("reset_k",        int'(bus.k),            0);
    check_output("reset_prep_ena", int'(bus.prep_ena),     0);
    check_output("reset_upd_ena",  int'(bus.upd_ena),      0);
    check_output("reset_done_ok",  int'(bus.done_ok),      0);
    check_output("reset_err",      int'(bus.err_overflow), 0);

    for (int i = 0; i < 5; i++) run_and_check(vecs[i], 1'b0);

    // ena held through PREP_WAIT/UPD_WAIT, then re-issued in the IDLE cycle after DONE.
    run_and_check('{v_target: 3, exp_prep: 3, exp_upd: 2, exp_k: 2, exp_done: 1, exp_err: 0}, 1'b1);
    bus.ena = 1'b1;
    @(negedge clk);
    bus.ena = 1'b0;
    check_output("restart_busy",    int'(bus.rdy),          0);
    check_output("restart_k_clear", int'(bus.k),            0);
    check_output("restart_done_clr", int'(bus.done_ok),     0);
    wait_idle("restart");
    check_output("restart_done_ok", int'(bus.done_ok),      1);
    check_output("restart_k",       int'(bus.k),            0);
    check_output("restart_prep",    prep_pulses,            4);
    check_output("restart_upd",     upd_pulses,             2);

    // Asynchronous reset in the third UPD_WAIT cycle of the second iteration.
    v_target = 0;
    cnt_clr  = 1'b1;
    @(negedge clk);
    cnt_clr  = 1'b0;
    bus.ena  = 1'b1;
    @(negedge clk);
    bus.ena  = 1'b0;
    seen = 0;
    n    = 0;
    while (seen < 2 && n < BUDGET) begin
      @(negedge clk);
      if (bus.upd_ena === 1'b1) seen++;
      n++;
    end
    check_output("second_upd_seen", seen, 2);
    repeat (3) @(negedge clk);
    check_output("k_before_reset", int'(bus.k), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midreset_rdy", int'(bus.rdy), 1);
    check_output("midreset_k",   int'(bus.k),   0);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.prep_ena !== 1'b0 || bus.upd_ena !== 1'b0) stray++;
    end
    check_output("no_pulse_after_reset", stray, 0);
    check_output("rdy_after_reset",      int'(bus.rdy), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
